// File: rtl/debug_pkg.sv
// debug_pkg: shared state and halt-cause encodings for the run-control engine
package debug_pkg;
    typedef enum logic [1:0] {
        RUN  = 2'b00,
        HALT = 2'b01,
        STEP = 2'b10
    } dbg_state_t;
    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_REQ  = 2'd1,
        CAUSE_STEP = 2'd2,
        CAUSE_BKPT = 2'd3
    } halt_cause_t;
endpackage

// File: rtl/debug_hart_ctl.sv
// debug_hart_ctl: per-hart run/halt/step FSM with step down-counter and halt cause
module debug_hart_ctl
    import debug_pkg::*;
#(
    parameter int STEP_W = 8
) (
    input  logic              sys_clk,
    input  logic              dbg_rst,
    input  logic              halt_req,
    input  logic              resume_req,
    input  logic              step_req,
    input  logic [STEP_W-1:0] step_count,
    input  logic              bkpt_hit,
    output logic              clk_en,
    output logic              halted,
    output logic [1:0]        halt_cause,
    output logic              step_done,
    output logic              busy
);
    dbg_state_t        state, state_d;
    halt_cause_t       cause, cause_d;
    logic [STEP_W-1:0] cnt, cnt_d;
    logic              done_d;
    always_comb begin
        state_d = state;
        cause_d = cause;
        cnt_d   = cnt;
        done_d  = 1'b0;
        case (state)
            RUN: begin
                if (halt_req) begin
                    state_d = HALT;
                    cause_d = CAUSE_REQ;
                end else if (bkpt_hit) begin
                    state_d = HALT;
                    cause_d = CAUSE_BKPT;
                end
            end
            HALT: begin
                if (step_req) begin
                    state_d = STEP;
                    cnt_d   = (step_count == '0) ? STEP_W'(1) : step_count;
                end else if (resume_req) begin
                    state_d = RUN;
                    cause_d = CAUSE_NONE;
                end
            end
            STEP: begin
                if (halt_req) begin
                    state_d = HALT;
                    cause_d = CAUSE_REQ;
                end else if (cnt == STEP_W'(1)) begin
                    state_d = HALT;
                    cause_d = CAUSE_STEP;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt - STEP_W'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end
    always_ff @(posedge sys_clk or negedge dbg_rst) begin
        if (!dbg_rst) begin
            state     <= RUN;
            cause     <= CAUSE_NONE;
            cnt       <= '0;
            clk_en    <= 1'b1;
            halted    <= 1'b0;
            busy      <= 1'b0;
            step_done <= 1'b0;
        end else begin
            state     <= state_d;
            cause     <= cause_d;
            cnt       <= cnt_d;
            clk_en    <= state_d != HALT;
            halted    <= state_d == HALT;
            busy      <= state_d == STEP;
            step_done <= done_d;
        end
    end
    assign halt_cause = cause;
endmodule

// File: rtl/debug_run_control.sv
// debug_run_control: multi-hart run-control, hart_sel request fan-out and output merge
module debug_run_control
    import debug_pkg::*;
#(
    parameter int NHARTS = 1,
    parameter int STEP_W = 8
) (
    input  logic                sys_clk,
    input  logic                dbg_rst,
    input  logic                halt_req,
    input  logic                resume_req,
    input  logic                step_req,
    input  logic [NHARTS-1:0]   hart_sel,
    input  logic [STEP_W-1:0]   step_count,
    input  logic [NHARTS-1:0]   bkpt,
    input  logic                bkpt_en,
    output logic [NHARTS-1:0]   clk_en,
    output logic [NHARTS-1:0]   halted,
    output logic [2*NHARTS-1:0] halt_cause,
    output logic [NHARTS-1:0]   step_done,
    output logic                busy
);
    logic [NHARTS-1:0] busy_h;
    for (genvar i = 0; i < NHARTS; i++) begin : g_hart
        debug_hart_ctl #(.STEP_W(STEP_W)) u_hart (
            .sys_clk    (sys_clk),
            .dbg_rst    (dbg_rst),
            .halt_req   (halt_req & hart_sel[i]),
            .resume_req (resume_req & hart_sel[i]),
            .step_req   (step_req & hart_sel[i]),
            .step_count (step_count),
            .bkpt_hit   (bkpt_en & bkpt[i]),
            .clk_en     (clk_en[i]),
            .halted     (halted[i]),
            .halt_cause (halt_cause[2*i+:2]),
            .step_done  (step_done[i]),
            .busy       (busy_h[i])
        );
    end
    assign busy = |busy_h;
endmodule

// File: tb/tb_debug_run_control.sv
// tb_debug_run_control: table vectors, corner sequences and random run against a cycle-end model
module tb_debug_run_control;
    localparam int NH = 2;
    localparam int SW = 8;
    localparam int M_RUN = 0, M_HALT = 1, M_STEP = 2;
    localparam int NV = 17;

    logic          sys_clk = 1'b0, dbg_rst = 1'b1;
    logic          halt_req = 1'b0, resume_req = 1'b0, step_req = 1'b0, bkpt_en = 1'b0;
    logic [NH-1:0] hart_sel = '0, bkpt = '0;
    logic [SW-1:0] step_count = '0;
    logic [NH-1:0] clk_en, halted, step_done;
    logic [2*NH-1:0] halt_cause;
    logic          busy;

    int     n_checks = 0, n_fail = 0;
    int     m_mode[NH], m_cause[NH];
    bit     m_done[NH];
    longint m_end[NH];
    longint cyc = 0;

    typedef struct packed {
        logic h, r, s;
        logic [1:0] sel;
        logic [7:0] cnt;
        logic [1:0] bk;
        logic bke;
        logic [1:0] e_en, e_halt;
        logic [3:0] e_cause;
        logic [1:0] e_done;
        logic e_busy;
    } vec_t;
    vec_t vt[NV];

    debug_run_control #(.NHARTS(NH), .STEP_W(SW)) dut (
        .sys_clk(sys_clk), .dbg_rst(dbg_rst), .halt_req(halt_req), .resume_req(resume_req),
        .step_req(step_req), .hart_sel(hart_sel), .step_count(step_count), .bkpt(bkpt),
        .bkpt_en(bkpt_en), .clk_en(clk_en), .halted(halted), .halt_cause(halt_cause),
        .step_done(step_done), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int h = 0; h < NH; h++) begin
            m_mode[h] = M_RUN; m_cause[h] = 0; m_done[h] = 0; m_end[h] = 0;
        end
    endtask

    // A step started at edge t ends at edge t+max(count,1): track the end edge, not a counter.
    task automatic model_edge();
        if (!dbg_rst) begin
            model_reset();
        end else begin
            for (int h = 0; h < NH; h++) begin
                bit sel = hart_sel[h];
                m_done[h] = 0;
                if (m_mode[h] == M_RUN) begin
                    if (halt_req && sel) begin m_mode[h] = M_HALT; m_cause[h] = 1; end
                    else if (bkpt_en && bkpt[h]) begin m_mode[h] = M_HALT; m_cause[h] = 3; end
                end else if (m_mode[h] == M_HALT) begin
                    if (step_req && sel) begin
                        m_mode[h] = M_STEP;
                        m_end[h] = cyc + ((step_count == 0) ? 1 : longint'(step_count));
                    end else if (resume_req && sel) begin
                        m_mode[h] = M_RUN; m_cause[h] = 0;
                    end
                end else begin
                    if (halt_req && sel) begin m_mode[h] = M_HALT; m_cause[h] = 1; end
                    else if (cyc == m_end[h]) begin m_mode[h] = M_HALT; m_cause[h] = 2; m_done[h] = 1; end
                end
            end
        end
        cyc++;
    endtask

    task automatic check_model(input string tag);
        logic [NH-1:0] e_en, e_h, e_d;
        logic [2*NH-1:0] e_c;
        logic e_b;
        e_b = 1'b0;
        for (int h = 0; h < NH; h++) begin
            e_en[h] = m_mode[h] != M_HALT;
            e_h[h] = m_mode[h] == M_HALT;
            e_c[2*h+:2] = 2'(m_cause[h]);
            e_d[h] = m_done[h];
            e_b |= m_mode[h] == M_STEP;
        end
        chk({tag, ".clk_en"}, 32'(clk_en), 32'(e_en));
        chk({tag, ".halted"}, 32'(halted), 32'(e_h));
        chk({tag, ".halt_cause"}, 32'(halt_cause), 32'(e_c));
        chk({tag, ".step_done"}, 32'(step_done), 32'(e_d));
        chk({tag, ".busy"}, 32'(busy), 32'(e_b));
    endtask

    task automatic drive(input logic h, r, s, input logic [NH-1:0] sel, input logic [SW-1:0] cnt,
                         input logic [NH-1:0] bk, input logic bke);
        halt_req = h; resume_req = r; step_req = s; hart_sel = sel;
        step_count = cnt; bkpt = bk; bkpt_en = bke;
        @(posedge sys_clk);
        model_edge();
        @(negedge sys_clk);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
    endtask

    task automatic run_step(input int h, input int n);
        int en_cnt, done_cnt, want;
        want = (n == 0) ? 1 : n;
        drive(1'b0, 1'b0, 1'b1, NH'(1 << h), SW'(n), '0, 1'b0);
        check_model("step_go");
        en_cnt = int'(clk_en[h]);
        done_cnt = 0;
        for (int k = 0; k < 400 && !halted[h]; k++) begin
            idle();
            check_model("step_run");
            en_cnt += int'(clk_en[h]);
            done_cnt += int'(step_done[h]);
        end
        idle();
        done_cnt += int'(step_done[h]);
        chk($sformatf("step%0d.len", n), 32'(en_cnt), 32'(want));
        chk($sformatf("step%0d.done_pulses", n), 32'(done_cnt), 32'd1);
        chk($sformatf("step%0d.halted", n), 32'(halted[h]), 32'd1);
        chk($sformatf("step%0d.cause", n), 32'(halt_cause[2*h+:2]), 32'd2);
    endtask

    initial begin
        int dn;
        vt[0]  = '{1'b0,1'b0,1'b0,2'b00,8'd0,2'b00,1'b0, 2'b11,2'b00,4'b0000,2'b00,1'b0};
        vt[1]  = '{1'b1,1'b0,1'b0,2'b01,8'd0,2'b00,1'b0, 2'b10,2'b01,4'b0001,2'b00,1'b0};
        vt[2]  = '{1'b0,1'b0,1'b1,2'b01,8'd2,2'b00,1'b0, 2'b11,2'b00,4'b0001,2'b00,1'b1};
        vt[3]  = '{1'b0,1'b0,1'b0,2'b00,8'd0,2'b00,1'b0, 2'b11,2'b00,4'b0001,2'b00,1'b1};
        vt[4]  = '{1'b0,1'b0,1'b0,2'b00,8'd0,2'b00,1'b0, 2'b10,2'b01,4'b0010,2'b01,1'b0};
        vt[5]  = '{1'b0,1'b0,1'b0,2'b00,8'd0,2'b00,1'b0, 2'b10,2'b01,4'b0010,2'b00,1'b0};
        vt[6]  = '{1'b0,1'b0,1'b0,2'b00,8'd0,2'b10,1'b1, 2'b00,2'b11,4'b1110,2'b00,1'b0};
        vt[7]  = '{1'b0,1'b0,1'b1,2'b10,8'd0,2'b10,1'b1, 2'b10,2'b01,4'b1110,2'b00,1'b1};
        vt[8]  = '{1'b0,1'b0,1'b0,2'b00,8'd0,2'b10,1'b1, 2'b00,2'b11,4'b1010,2'b10,1'b0};
        vt[9]  = '{1'b0,1'b1,1'b0,2'b11,8'd0,2'b00,1'b0, 2'b11,2'b00,4'b0000,2'b00,1'b0};
        vt[10] = '{1'b1,1'b0,1'b0,2'b11,8'd0,2'b11,1'b1, 2'b00,2'b11,4'b0101,2'b00,1'b0};
        vt[11] = '{1'b0,1'b1,1'b1,2'b01,8'd3,2'b00,1'b0, 2'b01,2'b10,4'b0101,2'b00,1'b1};
        vt[12] = '{1'b0,1'b1,1'b0,2'b01,8'd0,2'b00,1'b0, 2'b01,2'b10,4'b0101,2'b00,1'b1};
        vt[13] = '{1'b0,1'b1,1'b0,2'b10,8'd0,2'b00,1'b0, 2'b11,2'b00,4'b0001,2'b00,1'b1};
        vt[14] = '{1'b0,1'b0,1'b0,2'b00,8'd0,2'b00,1'b0, 2'b10,2'b01,4'b0010,2'b01,1'b0};
        vt[15] = '{1'b1,1'b0,1'b0,2'b00,8'd0,2'b00,1'b0, 2'b10,2'b01,4'b0010,2'b00,1'b0};
        vt[16] = '{1'b0,1'b1,1'b0,2'b01,8'd0,2'b00,1'b0, 2'b11,2'b00,4'b0000,2'b00,1'b0};
        model_reset();

        #2 dbg_rst = 1'b0;
        #1;
        chk("rst.clk_en", 32'(clk_en), 32'h3);
        chk("rst.halted", 32'(halted), 32'h0);
        chk("rst.halt_cause", 32'(halt_cause), 32'h0);
        chk("rst.step_done", 32'(step_done), 32'h0);
        chk("rst.busy", 32'(busy), 32'h0);
        drive(1'b1, 1'b0, 1'b0, 2'b11, '0, 2'b11, 1'b1);
        check_model("rst_hold");
        dbg_rst = 1'b1;

        for (int i = 0; i < NV; i++) begin
            drive(vt[i].h, vt[i].r, vt[i].s, vt[i].sel, vt[i].cnt, vt[i].bk, vt[i].bke);
            chk($sformatf("vec%0d.clk_en", i), 32'(clk_en), 32'(vt[i].e_en));
            chk($sformatf("vec%0d.halted", i), 32'(halted), 32'(vt[i].e_halt));
            chk($sformatf("vec%0d.halt_cause", i), 32'(halt_cause), 32'(vt[i].e_cause));
            chk($sformatf("vec%0d.step_done", i), 32'(step_done), 32'(vt[i].e_done));
            chk($sformatf("vec%0d.busy", i), 32'(busy), 32'(vt[i].e_busy));
        end

        drive(1'b1, 1'b0, 1'b0, 2'b01, '0, '0, 1'b0);
        check_model("pre_step");
        run_step(0, 5);
        run_step(0, 0);
        run_step(0, 1);
        run_step(0, 255);

        drive(1'b0, 1'b0, 1'b1, 2'b01, 8'd8, '0, 1'b0);
        check_model("abort_go");
        idle();
        check_model("abort_c2");
        drive(1'b1, 1'b0, 1'b0, 2'b01, '0, '0, 1'b0);
        check_model("abort_halt");
        chk("abort.halted", 32'(halted[0]), 32'd1);
        chk("abort.cause", 32'(halt_cause[1:0]), 32'd1);
        dn = int'(step_done[0]);
        for (int k = 0; k < 10; k++) begin
            idle();
            dn += int'(step_done[0]);
        end
        chk("abort.no_done", 32'(dn), 32'd0);

        for (int k = 0; k < 600; k++) begin
            drive($urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0,
                  NH'($urandom), ($urandom_range(0, 7) == 0) ? SW'($urandom) : SW'($urandom_range(0, 6)),
                  NH'(($urandom_range(0, 5) == 0) ? $urandom : 0), 1'($urandom));
            check_model("rand");
        end

        drive(1'b0, 1'b1, 1'b0, 2'b11, '0, '0, 1'b0);
        drive(1'b1, 1'b0, 1'b0, 2'b01, '0, '0, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 2'b01, 8'd50, '0, 1'b0);
        idle();
        idle();
        check_model("arst_pre");
        chk("arst.busy_before", 32'(busy), 32'd1);
        #2 dbg_rst = 1'b0;
        #1;
        chk("arst.clk_en", 32'(clk_en), 32'h3);
        chk("arst.halted", 32'(halted), 32'h0);
        chk("arst.busy", 32'(busy), 32'h0);
        chk("arst.halt_cause", 32'(halt_cause), 32'h0);
        model_reset();
        @(negedge sys_clk);
        dbg_rst = 1'b1;
        idle();
        check_model("arst_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/debug_run_control.md
# debug_run_control

Parametrised multi-hart run-control engine for the `sys_clk` debug domain. It generalises the single RUN/HALT/STEP debug core with:
- a per-hart state machine and per-hart clock enable;
- hart-select masking;
- multi-cycle stepping with a programmable step count;
- breakpoint-triggered halt and a halt-cause report.

It consumes request strobes that have already been synchronised into `sys_clk`, and drives `clk_en` into the existing negedge gating register. The gate itself stays outside this block.

## Interface
Parameters:
- NHARTS, 1, number of independently controlled harts
- STEP_W, 8, width of the step-count field

Ports:
- sys_clk  in  1  debug-domain clock; all state updates on posedge
- dbg_rst  in  1  reset, asynchronous and active-low
- halt_req  in  1  single-cycle strobe: halt the selected harts
- resume_req  in  1  single-cycle strobe: resume the selected harts
- step_req  in  1  single-cycle strobe: step the selected harts
- hart_sel  in  NHARTS  hart mask, sampled in the same cycle as any request strobe
- step_count  in  STEP_W  run cycles per step, sampled with step_req; value 0 is treated as 1
- bkpt  in  NHARTS  level breakpoint-hit flag from each hart
- bkpt_en  in  1  global breakpoint enable
- clk_en  out  NHARTS  per-hart clock enable, to the external gate
- halted  out  NHARTS  1 when the hart is in HALT
- halt_cause  out  2*NHARTS  per-hart cause, 2 bits per hart: NONE=0, REQ=1, STEP=2, BKPT=3
- step_done  out  NHARTS  one-cycle pulse when a step completes normally
- busy  out  1  OR across harts of state==STEP

## Operation
- Each hart runs its own FSM with states RUN, HALT and STEP, plus a down-counter `cnt[STEP_W-1:0]`.
- A request applies to hart i only if `hart_sel[i]`=1. With `hart_sel`=0 every request is ignored.
- RUN:
  - If `halt_req` is selected, go to HALT with cause REQ.
  - Otherwise, if `bkpt_en & bkpt[i]`, go to HALT with cause BKPT.
  - On entry to HALT, `clk_en` goes to 0.
  - `resume_req` and `step_req` are ignored.
- HALT:
  - If `step_req` is selected, go to STEP, load `cnt` = max(`step_count`,1), set `clk_en`=1.
  - Otherwise, if `resume_req` is selected, go to RUN, set `clk_en`=1, set cause to NONE.
  - Step has priority over resume. `halt_req` and `bkpt` are ignored.
- STEP:
  - If `halt_req` is selected, abort: go to HALT, cause REQ, `clk_en`=0, no `step_done`.
  - Otherwise, if `cnt`==1, go to HALT, cause STEP, `clk_en`=0, pulse `step_done[i]`.
  - Otherwise decrement `cnt`.
  - `bkpt` is ignored so the hart can step off a breakpoint. `resume_req` and `step_req` are ignored.
- `halt_cause` holds its value until the next HALT entry or a resume.

## Timing
- Reset values (async assert, while `dbg_rst`=0):
  - all harts in RUN
  - `clk_en` all ones
  - `halted`=0, `halt_cause`=0, `step_done`=0, `busy`=0, `cnt`=0
- Release of `dbg_rst` takes effect at the first posedge after deassertion. The async reset aborts a step in progress immediately.
- All outputs are registered. A request sampled at edge t is visible at outputs after edge t.
- Step length: a `step_req` at edge t gives `clk_en`=1 from edge t to edge t+N, i.e. exactly N `sys_clk` cycles with N = max(`step_count`,1). `step_done` is high for the single cycle after edge t+N.
- With `step_count` at maximum (2^STEP_W-1), `cnt` counts down without wrap.
- Simultaneous `halt_req` and `bkpt` in RUN: cause REQ.
- Harts are fully independent; different harts may be in different states in the same cycle.
- `halted[i]` and `clk_en[i]` are never both 1.

## Structure
- Package `debug_pkg`:
  - `dbg_state_t` enum: RUN=2'b00, HALT=2'b01, STEP=2'b10. These encodings match the existing debug core.
  - `halt_cause_t` enum, with the cause encodings listed under Interface.
- Sub-module `debug_hart_ctl`: one per hart, instantiated by a generate loop. It contains the FSM, the counter and the per-hart outputs.
- The top level only does request fan-out masked by `hart_sel`, output concatenation and the `busy` reduction.

## Test plan
1. Reset with NHARTS=2:
   - after reset, `clk_en`=2'b11, `halted`=0, `halt_cause`=0;
   - asserting `dbg_rst` low while a hart is in STEP returns it to RUN asynchronously.
2. `halt_req` with `hart_sel`=2'b01:
   - after the edge, hart0 has `halted`=1, `clk_en`=0, cause 1;
   - hart1 keeps running.
3. From HALT, `step_req` with `step_count`=5:
   - `clk_en` is high for exactly 5 cycles;
   - `step_done` pulses once, cause becomes 2, `halted`=1;
   - repeat with `step_count`=0 and check exactly 1 cycle.
4. `bkpt_en`=1 with `bkpt` asserted in RUN:
   - the hart halts with cause 3;
   - stepping from there with `bkpt` still high completes the step with no re-halt.
5. `halt_req` at cycle 2 of an 8-cycle step:
   - the hart halts immediately with cause 1;
   - no `step_done` pulse occurs.
6. Simultaneous `step_req` and `resume_req` in HALT:
   - the hart enters STEP;
   - a later `resume_req` returns it to RUN with cause 0.
